// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/control unit of the 5-stage
// MIPS core: opcode/function constants the decoder uses to classify
// producers and ID-stage consumers, default parameter values, and the
// scoreboard counter type for the default configuration.
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_pkg;

    // Primary opcodes and JR function code relevant to hazard classification
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Default configuration
    localparam int NREG_W_DEF   = 5;
    localparam int ALU_LAT_DEF  = 0;
    localparam int LOAD_LAT_DEF = 1;
    localparam int BR_EXTRA_DEF = 1;
    localparam int CNT_W_DEF    = 3;

    // Scoreboard counter for the default configuration
    typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// One down-counter per architectural register giving the number of cycles
// until the in-flight result for that register is forwardable to a branch
// consumer in ID. Counters hold while the back end is frozen, otherwise
// decrement towards zero; a load of a new producer overrides the decrement
// for its entry.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_hold                freeze: all counters keep their value
//   i_load                load i_load_val into entry i_load_num
//   i_load_num/i_load_val destination register and its countdown value
//   i_rd_a/i_rd_b         read addresses (rs, rt)
//   o_cnt_a/o_cnt_b       counter values at the read addresses
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG_W = NREG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic [NREG_W-1:0] i_load_num,
    input  logic [CNT_W-1:0]  i_load_val,
    input  logic [NREG_W-1:0] i_rd_a,
    input  logic [NREG_W-1:0] i_rd_b,
    output logic [CNT_W-1:0]  o_cnt_a,
    output logic [CNT_W-1:0]  o_cnt_b
);

    localparam int NENT = 2 ** NREG_W;

    logic [CNT_W-1:0] r_cnt [NENT];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NENT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!i_hold) begin
            for (int i = 0; i < NENT; i++) begin
                if (i_load && (i_load_num == NREG_W'(i))) begin
                    r_cnt[i] <= i_load_val;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign o_cnt_a = r_cnt[i_rd_a];
    assign o_cnt_b = r_cnt[i_rd_b];

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Stall, flush, freeze and PC-redirect control for the 5-stage MIPS core.
// A per-register scoreboard decides whether the instruction in ID may read
// its sources; dmem busy freezes the back end, imem busy stalls fetch, and a
// redirect resolved in ID is registered (and held across a busy fetch)
// before being presented to the pc block.
// Optional feature: define HAZARD_STATS_EN to add the saturating 32-bit
// stall_cycles / flush_cycles / freeze_cycles event counters.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   id_valid                     IF/ID holds a real instruction
//   id_rs, id_rt, id_use_rs/rt   source registers and read enables
//   id_wr_en, id_wr_num          destination write enable / register
//   id_is_load                   producer is lw/lbu
//   id_br_consumer               branch/JR reading operands in ID
//   id_redirect, id_target       taken branch / jump and its target
//   imem_busy, dmem_busy         memory handshakes
//   stall_if, stall_id           pc / if_id hold
//   flush_id                     if_id loads a NOP
//   bubble_ex                    id_ex loads a NOP
//   freeze_be                    id_ex, ex_mm, mm_wb hold
//   pc_load, pc_target           registered redirect to the pc block
//   issue                        ID instruction advances this cycle
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG_W   = NREG_W_DEF,
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int BR_EXTRA = BR_EXTRA_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [NREG_W-1:0] id_wr_num,
    input  logic              id_is_load,
    input  logic              id_br_consumer,
    input  logic              id_redirect,
    input  logic [31:0]       id_target,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              freeze_be,
    output logic              pc_load,
    output logic [31:0]       pc_target,
    output logic              issue
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles,
    output logic [31:0]       freeze_cycles
`endif
);

    localparam logic [CNT_W-1:0]  ALU_LOAD = CNT_W'(ALU_LAT + BR_EXTRA);
    localparam logic [CNT_W-1:0]  LD_LOAD  = CNT_W'(LOAD_LAT + BR_EXTRA);
    localparam logic [CNT_W-1:0]  BR_THR   = CNT_W'(BR_EXTRA);
    localparam logic [NREG_W-1:0] REG_ZERO = '0;

    logic [CNT_W-1:0] w_cnt_rs;
    logic [CNT_W-1:0] w_cnt_rt;
    logic             w_rs_blk;
    logic             w_rt_blk;
    logic             w_hazard;
    logic             w_sb_load;
    logic [CNT_W-1:0] w_sb_val;

    logic             r_pend;
    logic             r_pc_load;
    logic [31:0]      r_pc_target;

    // A normal consumer picks its operand up by forwarding later in the
    // pipe, so it only waits while the count exceeds the branch margin;
    // an ID-stage branch/JR needs the value now and waits for zero.
    assign w_rs_blk = id_br_consumer ? (w_cnt_rs != '0) : (w_cnt_rs > BR_THR);
    assign w_rt_blk = id_br_consumer ? (w_cnt_rt != '0) : (w_cnt_rt > BR_THR);
    assign w_hazard = (id_use_rs && (id_rs != REG_ZERO) && w_rs_blk) ||
                      (id_use_rt && (id_rt != REG_ZERO) && w_rt_blk);

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        freeze_be = 1'b0;
        issue     = 1'b0;
        if (dmem_busy) begin
            freeze_be = 1'b1;
            stall_if  = 1'b1;
            stall_id  = 1'b1;
        end else if (id_valid && w_hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            issue    = id_valid;
            stall_if = imem_busy;
            // IF/ID gets a NOP when fetch has nothing valid behind an
            // issuing instruction, on a redirect, and while a redirect is
            // still waiting for the fetch port so no wrong-path word enters.
            flush_id = (issue && (imem_busy || id_redirect)) || r_pend;
        end
    end

    assign w_sb_load = issue && id_wr_en && (id_wr_num != REG_ZERO);
    assign w_sb_val  = id_is_load ? LD_LOAD : ALU_LOAD;

    hazard_scoreboard #(
        .NREG_W (NREG_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_hold     (dmem_busy),
        .i_load     (w_sb_load),
        .i_load_num (id_wr_num),
        .i_load_val (w_sb_val),
        .i_rd_a     (id_rs),
        .i_rd_b     (id_rt),
        .o_cnt_a    (w_cnt_rs),
        .o_cnt_b    (w_cnt_rt)
    );

    // Redirect target is captured at issue; the load pulse is deferred
    // until the fetch port is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
        end else begin
            r_pc_load <= 1'b0;
            if (issue && id_redirect) begin
                r_pc_target <= id_target;
                if (imem_busy) begin
                    r_pend <= 1'b1;
                end else begin
                    r_pc_load <= 1'b1;
                end
            end else if (r_pend && !imem_busy) begin
                r_pc_load <= 1'b1;
                r_pend    <= 1'b0;
            end
        end
    end

    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_freeze_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (stall_id && !freeze_be && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_id && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (freeze_be && (r_freeze_cnt != '1)) begin
                r_freeze_cnt <= r_freeze_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cnt;
    assign flush_cycles  = r_flush_cnt;
    assign freeze_cycles = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int NREG_W   = 5;
    localparam int ALU_LAT  = 0;
    localparam int LOAD_LAT = 1;
    localparam int BR_EXTRA = 1;
    localparam int CNT_W    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic        id_wr_en;
    logic [4:0]  id_wr_num;
    logic        id_is_load, id_br_consumer, id_redirect;
    logic [31:0] id_target;
    logic        imem_busy, dmem_busy;
    logic        stall_if, stall_id, flush_id, bubble_ex, freeze_be;
    logic        pc_load, issue;
    logic [31:0] pc_target;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles, freeze_cycles;
`endif

    hazard_ctrl #(
        .NREG_W(NREG_W), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
        .BR_EXTRA(BR_EXTRA), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .id_br_consumer(id_br_consumer), .id_redirect(id_redirect), .id_target(id_target),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .freeze_be(freeze_be), .pc_load(pc_load),
        .pc_target(pc_target), .issue(issue)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
        .freeze_cycles(freeze_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // {stall_if, stall_id, flush_id, bubble_ex, freeze_be, issue}
    function automatic logic [5:0] ctl();
        return {stall_if, stall_id, flush_id, bubble_ex, freeze_be, issue};
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_num = 0; id_is_load = 0; id_br_consumer = 0;
        id_redirect = 0; id_target = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    // Leaves the caller at a negedge with reset deasserted and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    // Drive a producer for one cycle (caller is at a negedge).
    task automatic producer(input logic [4:0] num, input logic ld);
        clear_inputs();
        id_valid = 1; id_wr_en = 1; id_wr_num = num; id_is_load = ld;
        @(negedge clk);
    endtask

    task automatic consumer(input logic [4:0] rs, input logic [4:0] rt, input logic br);
        clear_inputs();
        id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = 1; id_use_rt = 1;
        id_br_consumer = br; id_wr_en = !br; id_wr_num = br ? 5'd0 : 5'd3;
    endtask

    typedef struct {
        logic       pre_en;
        logic [4:0] pre_num;
        logic       pre_load;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       redir;
        logic       imem;
        logic       dmem;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[16];

    // Behavioural model: each register gets the "active" time (cycles
    // without dmem_busy) from which an ID branch may read it.
    int          ready_br[32];
    int          now_act;
    logic        m_pend, m_pc_load;
    logic [31:0] m_pc_target;

    function automatic bit blocked(input logic [4:0] r, input logic br);
        if (r == 5'd0) return 1'b0;
        if (br) return now_act < ready_br[r];
        return now_act < (ready_br[r] - BR_EXTRA);
    endfunction

    task automatic model_reset();
        now_act = 0;
        for (int i = 0; i < 32; i++) ready_br[i] = 0;
        m_pend = 0; m_pc_load = 0; m_pc_target = 0;
    endtask

    initial begin
        reset = 0;
        clear_inputs();

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("reset_ctl", 64'(ctl()), 64'd0);
        chk("reset_pc", {31'd0, pc_load, pc_target}, 64'd0);

        // ---------------- table-driven single-cycle cases ----------------
        tbl[0]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
        tbl[2]  = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110100};
        tbl[3]  = '{1'b1, 5'd2, 1'b0, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
        tbl[4]  = '{1'b1, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};
        tbl[5]  = '{1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};
        tbl[6]  = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
        tbl[7]  = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
        tbl[8]  = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110100};
        tbl[9]  = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b110010};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b101001};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b100000};
        tbl[12] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001001};
        tbl[13] = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110100};
        tbl[14] = '{1'b1, 5'd2, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110100};
        tbl[15] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110010};

        for (int v = 0; v < 16; v++) begin
            do_reset();
            if (tbl[v].pre_en) producer(tbl[v].pre_num, tbl[v].pre_load);
            clear_inputs();
            id_valid = tbl[v].valid; id_rs = tbl[v].rs; id_rt = tbl[v].rt;
            id_use_rs = tbl[v].use_rs; id_use_rt = tbl[v].use_rt;
            id_br_consumer = tbl[v].br; id_redirect = tbl[v].redir;
            id_target = 32'h100; imem_busy = tbl[v].imem; dmem_busy = tbl[v].dmem;
            #1;
            chk($sformatf("vec%0d", v), 64'(ctl()), 64'(tbl[v].exp));
        end

        // ---------------- load-use: one bubble ----------------
        do_reset();
        clear_inputs();
        id_valid = 1; id_wr_en = 1; id_wr_num = 5'd2; id_is_load = 1;
        #1 chk("lu_lw_issue", 64'(ctl()), 64'b000001);
        @(negedge clk);
        consumer(5'd2, 5'd4, 1'b0);
        #1 chk("lu_stall", 64'(ctl()), 64'b110100);
        @(negedge clk);
        #1 chk("lu_issue", 64'(ctl()), 64'b000001);
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef HAZARD_STATS_EN
        chk("stats_stall", 64'(stall_cycles), 64'd1);
        chk("stats_flush", 64'(flush_cycles), 64'd0);
        chk("stats_freeze", 64'(freeze_cycles), 64'd0);
`endif

        // ---------------- branch consumers ----------------
        do_reset();
        producer(5'd5, 1'b0);
        consumer(5'd5, 5'd0, 1'b1);
        #1 chk("br_alu_stall", 64'(ctl()), 64'b110100);
        @(negedge clk);
        #1 chk("br_alu_issue", 64'(ctl()), 64'b000001);

        do_reset();
        producer(5'd5, 1'b1);
        consumer(5'd5, 5'd0, 1'b1);
        #1 chk("br_lw_stall1", 64'(ctl()), 64'b110100);
        @(negedge clk);
        #1 chk("br_lw_stall2", 64'(ctl()), 64'b110100);
        @(negedge clk);
        #1 chk("br_lw_issue", 64'(ctl()), 64'b000001);

        // ---------------- dmem freeze holds the scoreboard ----------------
        do_reset();
        producer(5'd6, 1'b1);
        consumer(5'd6, 5'd0, 1'b0);
        dmem_busy = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("frz%0d", k), 64'(ctl()), 64'b110010);
            @(negedge clk);
        end
        dmem_busy = 0;
        #1 chk("frz_bubble", 64'(ctl()), 64'b110100);
        @(negedge clk);
        #1 chk("frz_issue", 64'(ctl()), 64'b000001);

        // ---------------- redirect across busy fetch ----------------
        do_reset();
        clear_inputs();
        id_valid = 1; id_use_rs = 1; id_br_consumer = 1; id_redirect = 1;
        id_target = 32'h40; imem_busy = 1;
        #1 chk("rd_issue", 64'(ctl()), 64'b101001);
        @(negedge clk);
        clear_inputs(); imem_busy = 1;
        #1 chk("rd_busy2", {31'd0, ctl(), pc_load}, {31'd0, 6'b101000, 1'b0});
        @(negedge clk);
        imem_busy = 0;
        #1 chk("rd_fall", {31'd0, ctl(), pc_load}, {31'd0, 6'b001000, 1'b0});
        @(negedge clk);
        #1 chk("rd_load", {31'd0, pc_load, pc_target}, {31'd0, 1'b1, 32'h40});
        chk("rd_idle", 64'(ctl()), 64'd0);
        @(negedge clk);
        #1 chk("rd_done", 64'(pc_load), 64'd0);

        // ---------------- reset during a load hazard ----------------
        do_reset();
        producer(5'd2, 1'b1);
        consumer(5'd2, 5'd4, 1'b0);
        #1 chk("rst_haz", 64'(ctl()), 64'b110100);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1 chk("rst_after", {31'd0, ctl(), pc_load}, {31'd0, 6'b000001, 1'b0});
        chk("rst_tgt", 64'(pc_target), 64'd0);

        // ---------------- randomized vs behavioural model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] e_ctl;
            logic       e_haz, e_issue;
            @(negedge clk);
            reset          = ($urandom_range(0, 99) == 0);
            id_valid       = m_pend ? 1'b0 : ($urandom_range(0, 3) != 0);
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_use_rs      = 1'($urandom_range(0, 1));
            id_use_rt      = 1'($urandom_range(0, 1));
            id_wr_en       = 1'($urandom_range(0, 1));
            id_wr_num      = 5'($urandom_range(0, 3));
            id_is_load     = 1'($urandom_range(0, 1));
            id_br_consumer = ($urandom_range(0, 3) == 0);
            id_redirect    = ($urandom_range(0, 4) == 0);
            id_target      = $urandom;
            imem_busy      = ($urandom_range(0, 3) == 0);
            dmem_busy      = ($urandom_range(0, 5) == 0);
            #1;
            e_haz = id_valid && ((id_use_rs && blocked(id_rs, id_br_consumer)) ||
                                 (id_use_rt && blocked(id_rt, id_br_consumer)));
            e_issue = 1'b0;
            if (dmem_busy) e_ctl = 6'b110010;
            else if (e_haz) e_ctl = 6'b110100;
            else begin
                e_issue = id_valid;
                e_ctl = {imem_busy, 1'b0,
                         (e_issue && (imem_busy || id_redirect)) || m_pend,
                         1'b0, 1'b0, e_issue};
            end
            chk($sformatf("rnd_ctl%0d", c), 64'(ctl()), 64'(e_ctl));
            chk($sformatf("rnd_pc%0d", c), {31'd0, pc_load, pc_target},
                {31'd0, m_pc_load, m_pc_target});
            if (reset) begin
                model_reset();
            end else begin
                if (!dmem_busy) begin
                    if (e_issue && id_wr_en && id_wr_num != 5'd0)
                        ready_br[id_wr_num] = now_act + 1 + BR_EXTRA +
                                              (id_is_load ? LOAD_LAT : ALU_LAT);
                    now_act++;
                end
                m_pc_load = 0;
                if (e_issue && id_redirect) begin
                    m_pc_target = id_target;
                    if (imem_busy) m_pend = 1;
                    else m_pc_load = 1;
                end else if (m_pend && !imem_busy) begin
                    m_pc_load = 1;
                    m_pend = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
